// File: rtl/ps2_key_decoder_if.sv
// Key event bundle between the PS/2 decoder (master) and the game FSM (slave).
// Carries direction/pause pulses, the last received byte and frame status.
interface ps2_key_decoder_if;
    logic       kup;
    logic       kright;
    logic       kdown;
    logic       kleft;
    logic       kpause;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    modport master (
        output kup, kright, kdown, kleft, kpause,
        output scan_code, scan_valid, frame_err
    );

    modport slave (
        input kup, kright, kdown, kleft, kpause,
        input scan_code, scan_valid, frame_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and arrow/pause make-code decoder with typematic filter.
// Ports: clock, reset (async, active-low), ps2_clk/ps2_data raw pins, kif (master) events.
// Optional: define KEY_WASD_EN to also map W/D/S/A base codes to the directions.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    ps2_key_decoder_if.master  kif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic             r_clk_s1, r_clk_s2, r_clk_d;
    logic             r_dat_s1, r_dat_s2;
    logic [3:0]       r_bit_cnt;
    logic [9:0]       r_frame;
    logic [CNT_W-1:0] r_to_cnt;
    logic [7:0]       r_scan_code;
    logic             r_scan_valid;
    logic             r_frame_err;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [8:0]       r_held;
    logic [8:0]       w_held_nxt;
    logic [4:0]       r_pulse;
    logic [4:0]       w_pulse_nxt;

    logic             w_fall;
    logic             w_ok;
    logic             w_ext;
    logic             w_brk;
    logic             w_ev;
    logic [8:0]       w_slot;
    logic [8:0]       w_fire;

    // r_frame[0]=start, [8:1]=D7..D0, [9]=parity; stop is the bit arriving now
    assign w_fall = r_clk_d & ~r_clk_s2;
    assign w_ok   = ~r_frame[0] & (^r_frame[9:1]) & r_dat_s2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_clk_s1     <= 1'b1;
            r_clk_s2     <= 1'b1;
            r_clk_d      <= 1'b1;
            r_dat_s1     <= 1'b1;
            r_dat_s2     <= 1'b1;
            r_bit_cnt    <= '0;
            r_frame      <= '0;
            r_to_cnt     <= '0;
            r_scan_code  <= 8'h00;
            r_scan_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_clk_s1     <= ps2_clk;
            r_clk_s2     <= r_clk_s1;
            r_clk_d      <= r_clk_s2;
            r_dat_s1     <= ps2_data;
            r_dat_s2     <= r_dat_s1;
            r_scan_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt <= '0;
                    if (w_ok) begin
                        r_scan_code  <= r_frame[8:1];
                        r_scan_valid <= 1'b1;
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end else begin
                    r_frame   <= {r_dat_s2, r_frame[9:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (r_bit_cnt != 4'd0) begin
                // stalled partial frame is silently abandoned
                if (r_to_cnt == TO_MAX) begin
                    r_bit_cnt <= '0;
                    r_to_cnt  <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_held  <= '0;
            r_pulse <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_held  <= w_held_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_frame_err) begin
            w_state_nxt = S_IDLE;
        end else if (r_scan_valid) begin
            unique case (r_state)
                S_IDLE: begin
                    if (r_scan_code == 8'hE0)
                        w_state_nxt = S_EXT;
                    else if (r_scan_code == 8'hF0)
                        w_state_nxt = S_BRK;
                end
                S_EXT: begin
                    if (r_scan_code == 8'hF0)
                        w_state_nxt = S_EXT_BRK;
                    else
                        w_state_nxt = S_IDLE;
                end
                S_BRK:     w_state_nxt = S_IDLE;
                S_EXT_BRK: w_state_nxt = S_IDLE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Prefix bytes (E0/F0) are state changes, not key events
    always_comb begin
        w_ext  = (r_state == S_EXT) || (r_state == S_EXT_BRK);
        w_brk  = (r_state == S_BRK) || (r_state == S_EXT_BRK);
        w_ev   = r_scan_valid
               && !((r_state == S_IDLE)
                    && ((r_scan_code == 8'hE0) || (r_scan_code == 8'hF0)))
               && !((r_state == S_EXT) && (r_scan_code == 8'hF0));
        w_slot    = '0;
        w_slot[0] = w_ext  && (r_scan_code == 8'h75);
        w_slot[1] = w_ext  && (r_scan_code == 8'h74);
        w_slot[2] = w_ext  && (r_scan_code == 8'h72);
        w_slot[3] = w_ext  && (r_scan_code == 8'h6B);
        w_slot[4] = !w_ext && (r_scan_code == 8'h4D);
`ifdef KEY_WASD_EN
        w_slot[5] = !w_ext && (r_scan_code == 8'h1D);
        w_slot[6] = !w_ext && (r_scan_code == 8'h23);
        w_slot[7] = !w_ext && (r_scan_code == 8'h1B);
        w_slot[8] = !w_ext && (r_scan_code == 8'h1C);
`endif
        w_slot = w_slot & {9{w_ev}};
        // held keys do not re-fire on typematic repeat
        w_fire = w_brk ? 9'd0 : (w_slot & ~r_held);
        w_held_nxt = w_brk ? (r_held & ~w_slot) : (r_held | w_slot);
        w_pulse_nxt = {
            w_fire[4],
            w_fire[3] | w_fire[8],
            w_fire[2] | w_fire[7],
            w_fire[1] | w_fire[6],
            w_fire[0] | w_fire[5]
        };
    end

    assign kif.kup        = r_pulse[0];
    assign kif.kright     = r_pulse[1];
    assign kif.kdown      = r_pulse[2];
    assign kif.kleft      = r_pulse[3];
    assign kif.kpause     = r_pulse[4];
    assign kif.scan_code  = r_scan_code;
    assign kif.scan_valid = r_scan_valid;
    assign kif.frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: PS/2 frames driven bit by bit,
// event pulses counted on the falling system clock edge and checked.
module tb_ps2_key_decoder;

    localparam int TO = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    ps2_key_decoder_if kif ();

    ps2_key_decoder #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W(8)
    ) u_dut (
        .clock(clk),
        .reset(rst_n),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .kif(kif)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_up = 0, n_rt = 0, n_dn = 0, n_lf = 0, n_ps = 0;
    int n_val = 0, n_err = 0, n_multi = 0;

    always @(negedge clk) begin
        if (kif.kup)        n_up++;
        if (kif.kright)     n_rt++;
        if (kif.kdown)      n_dn++;
        if (kif.kleft)      n_lf++;
        if (kif.kpause)     n_ps++;
        if (kif.scan_valid) n_val++;
        if (kif.frame_err)  n_err++;
        if (32'(kif.kup) + 32'(kif.kright) + 32'(kif.kdown)
            + 32'(kif.kleft) + 32'(kif.kpause) > 1)
            n_multi++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            cyc(10);
            ps2_clk = 1'b0;
            cyc(10);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input logic bad_par = 1'b0);
        logic p;
        p = ~^d ^ bad_par;
        send_bits({1'b1, p, d, 1'b0}, 11);
        cyc(20);
    endtask

    initial begin
        cyc(3);
        #1;
        chk("rst_scan_code", int'(kif.scan_code), 0);
        chk("rst_pulses", int'({kif.kup, kif.kright, kif.kdown,
            kif.kleft, kif.kpause, kif.scan_valid, kif.frame_err}), 0);
        rst_n = 1'b1;
        cyc(5);

        // partial frame killed by reset
        send_bits(11'b111_1110_0000, 5);
        cyc(3);
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(5);
        send(8'hE0);
        send(8'h75);
        chk("up_first", n_up, 1);
        chk("scan_75", int'(kif.scan_code), 'h75);
        chk("no_err_1", n_err, 0);
        chk("valid_cnt_1", n_val, 2);

        // typematic repeat
        repeat (3) begin
            send(8'hE0);
            send(8'h75);
        end
        chk("up_repeat", n_up, 1);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk("up_break", n_up, 1);
        send(8'hE0);
        send(8'h75);
        chk("up_second", n_up, 2);

        // parity error
        send(8'h4D, 1'b1);
        chk("perr_cnt", n_err, 1);
        chk("perr_no_pause", n_ps, 0);
        chk("perr_scan_kept", int'(kif.scan_code), 'h75);
        send(8'h4D);
        chk("pause_make", n_ps, 1);

        // timeout of partial frame
        send_bits(11'b111_1111_1110, 5);
        cyc(TO + 10);
        send(8'hE0);
        send(8'h6B);
        chk("left_after_to", n_lf, 1);
        chk("no_err_to", n_err, 1);
        chk("scan_6b", int'(kif.scan_code), 'h6B);

        // optional WASD mapping
        n_val = 0;
        send(8'h1D);
        chk("wasd_valid", n_val, 1);
`ifdef KEY_WASD_EN
        chk("wasd_up", n_up, 3);
`else
        chk("wasd_up", n_up, 2);
`endif

        // base break then make
        send(8'hF0);
        send(8'h4D);
        chk("pause_break", n_ps, 1);
        send(8'h4D);
        chk("pause_remake", n_ps, 2);

        // stop bit error returns EXT to IDLE
        send(8'hE0);
        send_bits({1'b0, 1'b0, 8'h74, 1'b0}, 11);
        cyc(20);
        chk("stop_err", n_err, 2);
        send(8'h74);
        chk("no_right_base", n_rt, 0);
        send(8'hE0);
        send(8'h74);
        chk("right_ext", n_rt, 1);
        send(8'hE0);
        send(8'h72);
        chk("down_ext", n_dn, 1);

        chk("one_pulse_max", n_multi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
